// File: rtl/run_ctrl_fsm.sv
// Run/step/stop controller for the Mic-1 core: synchronised, debounced button
// presses drive a Moore FSM that gates mic1_run and emits a core reset pulse.
module run_ctrl_fsm #(
    parameter int unsigned DB_CYCLES = 16,
    parameter int unsigned STEP_LEN  = 1,
    parameter int unsigned CNT_W     = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [4:0]       button,
    output logic             mic1_run,
    output logic             mic1_reset,
    output logic             led_start_stop,
    output logic             led_step,
    output logic [CNT_W-1:0] led_run,
    output logic [1:0]       state_o
);

    localparam int unsigned DB_W  = $clog2(DB_CYCLES);
    localparam int unsigned LEN_W = (STEP_LEN > 1) ? $clog2(STEP_LEN) : 1;

    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_CYCLES - 1);
    localparam logic [LEN_W-1:0] LEN_LOAD = LEN_W'(STEP_LEN - 1);

    localparam int unsigned B_RUN   = 0;
    localparam int unsigned B_STEP  = 2;
    localparam int unsigned B_STOP  = 3;
    localparam int unsigned B_RSYNC = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StStop = 2'd2,
        StStep = 2'd3
    } state_e;

    logic [4:0]      sync1_q, sync2_q;
    logic [4:0]      db_q, db_prev_q;
    logic [DB_W-1:0] db_cnt_q [5];
    logic [4:0]      press;
    logic            unused_press;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] step_cnt_q, step_cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             mic1_reset_q, mic1_reset_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            db_q      <= '0;
            db_prev_q <= '0;
            for (int i = 0; i < 5; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= button;
            sync2_q   <= sync1_q;
            db_prev_q <= db_q;
            // Count consecutive differing samples; any agreeing sample restarts the count.
            for (int i = 0; i < 5; i++) begin
                if (sync2_q[i] != db_q[i]) begin
                    if (db_cnt_q[i] == DB_LAST) begin
                        db_q[i]     <= sync2_q[i];
                        db_cnt_q[i] <= '0;
                    end else begin
                        db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
                    end
                end else begin
                    db_cnt_q[i] <= '0;
                end
            end
        end
    end

    assign press        = db_q & ~db_prev_q;
    assign unused_press = press[1];

    always_comb begin
        state_d      = state_q;
        step_cnt_d   = step_cnt_q;
        len_d        = len_q;
        mic1_reset_d = 1'b0;
        if (press[B_RSYNC]) begin
            state_d      = StIdle;
            step_cnt_d   = '0;
            len_d        = '0;
            mic1_reset_d = 1'b1;
        end else begin
            unique case (state_q)
                StIdle, StStop: begin
                    // A coincident STOP outranks STEP/RUN and is itself ignored here.
                    if (!press[B_STOP]) begin
                        if (press[B_STEP]) begin
                            state_d    = StStep;
                            step_cnt_d = step_cnt_q + 1'b1;
                            len_d      = LEN_LOAD;
                        end else if (press[B_RUN]) begin
                            state_d = StRun;
                        end
                    end
                end
                StRun: begin
                    if (press[B_STOP]) begin
                        state_d = StStop;
                    end
                end
                StStep: begin
                    if (press[B_STOP] || (len_q == '0)) begin
                        state_d = StStop;
                    end else begin
                        len_d = len_q - 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= StIdle;
            step_cnt_q   <= '0;
            len_q        <= '0;
            mic1_reset_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            step_cnt_q   <= step_cnt_d;
            len_q        <= len_d;
            mic1_reset_q <= mic1_reset_d;
        end
    end

    assign mic1_run       = (state_q == StRun) || (state_q == StStep);
    assign mic1_reset     = mic1_reset_q;
    assign led_start_stop = (state_q == StRun);
    assign led_step       = (state_q == StStop);
    assign led_run        = step_cnt_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_run_ctrl_fsm.sv
// Bench for run_ctrl_fsm: directed button sequences, a sample-history model of
// the debounce/FSM behaviour compared every cycle, plus literal spot checks.
module tb_run_ctrl_fsm;

    localparam int DB = 4;
    localparam int SL = 3;
    localparam int CW = 4;

    logic          clk;
    logic          resetn;
    logic [4:0]    button;
    logic          mic1_run;
    logic          mic1_reset;
    logic          led_start_stop;
    logic          led_step;
    logic [CW-1:0] led_run;
    logic [1:0]    state_o;

    int tests = 0;
    int fails = 0;

    run_ctrl_fsm #(
        .DB_CYCLES(DB),
        .STEP_LEN (SL),
        .CNT_W    (CW)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .button        (button),
        .mic1_run      (mic1_run),
        .mic1_reset    (mic1_reset),
        .led_start_stop(led_start_stop),
        .led_step      (led_step),
        .led_run       (led_run),
        .state_o       (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Model: 0 IDLE, 1 RUN, 2 STOP, 3 STEP. m_left = run cycles still owed in STEP.
    int         m_state = 0;
    int         m_steps = 0;
    int         m_left  = 0;
    bit         m_rpulse = 0;
    bit   [4:0] m_level = '0;
    bit   [4:0] m_pend  = '0;
    logic [4:0] hist[$];
    int         ev;
    bit         stable;
    logic       s;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_state  = 0;
            m_steps  = 0;
            m_left   = 0;
            m_rpulse = 0;
            m_level  = '0;
            m_pend   = '0;
            hist.delete();
        end else begin
            m_rpulse = 0;
            if (m_pend[4]) begin
                m_state  = 0;
                m_steps  = 0;
                m_left   = 0;
                m_rpulse = 1;
            end else begin
                ev = -1;
                if (m_pend[3]) ev = 3;
                else if (m_pend[2]) ev = 2;
                else if (m_pend[0]) ev = 0;
                case (m_state)
                    0, 2: begin
                        if (ev == 2) begin
                            m_state = 3;
                            m_steps = (m_steps + 1) % (1 << CW);
                            m_left  = SL;
                        end else if (ev == 0) begin
                            m_state = 1;
                        end
                    end
                    1: if (ev == 3) m_state = 2;
                    default: begin
                        m_left = m_left - 1;
                        if (ev == 3 || m_left == 0) m_state = 2;
                    end
                endcase
            end
            // Level flips once the DB samples seen by the debouncer (raw taken
            // 2..DB+1 edges ago) all disagree with it.
            hist.push_front(button);
            m_pend = '0;
            for (int b = 0; b < 5; b++) begin
                stable = 1;
                for (int k = 2; k <= DB + 1; k++) begin
                    s = (k < hist.size()) ? hist[k][b] : 1'b0;
                    if (s == m_level[b]) stable = 0;
                end
                if (stable) begin
                    m_level[b] = ~m_level[b];
                    if (m_level[b]) m_pend[b] = 1;
                end
            end
            if (hist.size() > 16) void'(hist.pop_back());
        end
    end

    always @(negedge clk) begin
        chk("state_o",        int'(state_o),        m_state);
        chk("mic1_run",       int'(mic1_run),       (m_state == 1 || m_state == 3) ? 1 : 0);
        chk("mic1_reset",     int'(mic1_reset),     int'(m_rpulse));
        chk("led_start_stop", int'(led_start_stop), (m_state == 1) ? 1 : 0);
        chk("led_step",       int'(led_step),       (m_state == 2) ? 1 : 0);
        chk("led_run",        int'(led_run),        m_steps);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_state_o"},   int'(state_o),        0);
        chk({tag, "_run"},       int'(mic1_run),       0);
        chk({tag, "_reset"},     int'(mic1_reset),     0);
        chk({tag, "_led_ss"},    int'(led_start_stop), 0);
        chk({tag, "_led_step"},  int'(led_step),       0);
        chk({tag, "_led_run"},   int'(led_run),        0);
    endtask

    // Hold a button pattern for n cycles then release for m, counting output pulses.
    task automatic press_win(input logic [4:0] pat, input int n, input int m,
                             output int runs, output int rsts);
        runs = 0;
        rsts = 0;
        button = pat;
        for (int j = 0; j < n + m; j++) begin
            if (j == n) button = '0;
            @(negedge clk);
            runs += int'(mic1_run);
            rsts += int'(mic1_reset);
        end
    endtask

    int runs, rsts, first;

    initial begin
        resetn = 1'b1;
        button = '0;
        #1 resetn = 1'b0;
        #1 all_zero("reset");
        cyc(2);
        resetn = 1'b1;
        cyc(3);

        // RUN held 10 cycles from IDLE: outputs rise on cycle 7, no repeat.
        button = 5'b00001;
        cyc(6);
        chk("run_cyc6_state", int'(state_o), 0);
        cyc(1);
        chk("run_cyc7_state", int'(state_o), 1);
        chk("run_cyc7_mic1_run", int'(mic1_run), 1);
        chk("run_cyc7_led_ss", int'(led_start_stop), 1);
        cyc(3);
        button = '0;
        cyc(12);
        chk("run_hold_state", int'(state_o), 1);

        press_win(5'b01000, 8, 8, runs, rsts);
        chk("stop_state", int'(state_o), 2);
        chk("stop_led_step", int'(led_step), 1);

        // 3-cycle STEP glitch must be filtered.
        press_win(5'b00100, 3, 10, runs, rsts);
        chk("glitch_state", int'(state_o), 2);
        chk("glitch_led_run", int'(led_run), 0);
        chk("glitch_runs", runs, 0);

        for (int i = 0; i < 16; i++) begin
            press_win(5'b00100, 8, 8, runs, rsts);
            chk("step_runs", runs, 3);
            chk("step_led_run", int'(led_run), (i + 1) % 16);
            chk("step_state", int'(state_o), 2);
        end

        press_win(5'b00100, 8, 8, runs, rsts);
        chk("extra_step_led_run", int'(led_run), 1);
        press_win(5'b00001, 8, 8, runs, rsts);
        chk("rerun_state", int'(state_o), 1);

        // RUN, STOP and RESET_SYNC together in RUN: reset wins.
        press_win(5'b11001, 8, 8, runs, rsts);
        chk("rsync_pulses", rsts, 1);
        chk("rsync_state", int'(state_o), 0);
        chk("rsync_led_run", int'(led_run), 0);

        // STOP arriving in the second step cycle cuts the step to 2 run cycles.
        button = 5'b00100;
        cyc(2);
        press_win(5'b01100, 14, 10, runs, rsts);
        chk("abort_runs", runs, 2);
        chk("abort_state", int'(state_o), 2);
        chk("abort_led_run", int'(led_run), 1);

        // Reset in the middle of a step and of a RUN debounce.
        button = 5'b00100;
        cyc(4);
        button = 5'b00101;
        cyc(4);
        chk("midstep_run", int'(mic1_run), 1);
        chk("midstep_state", int'(state_o), 3);
        #2 resetn = 1'b0;
        #1 all_zero("async");
        button = 5'b00100;
        cyc(2);
        resetn = 1'b1;
        runs = 0;
        first = 0;
        for (int j = 1; j <= 14; j++) begin
            @(negedge clk);
            if (mic1_run && first == 0) first = j;
            runs += int'(mic1_run);
        end
        chk("held_first_run", first, 7);
        chk("held_runs", runs, 3);
        chk("held_led_run", int'(led_run), 1);
        button = '0;
        cyc(10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/run_ctrl_fsm.md
RUN_CTRL_FSM -- requirements
Module: run_ctrl_fsm

Interface
REQ-001 Parameter DB_CYCLES, default 16: number of consecutive stable synchronised samples required to accept a button level change (minimum 2).
REQ-002 Parameter STEP_LEN, default 1: number of cycles mic1_run is asserted per single step (minimum 1).
REQ-003 Parameter CNT_W, default 4: width of the step counter and led_run (minimum 1).
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 resetn  input  1  asynchronous, active-low reset.
REQ-006 button  input  5  raw asynchronous buttons: [0] RUN, [1] unused, [2] STEP, [3] STOP, [4] RESET_SYNC.
REQ-007 mic1_run  output  1  run enable to the Mic-1 core.
REQ-008 mic1_reset  output  1  one-cycle synchronous reset pulse to the Mic-1 core.
REQ-009 led_start_stop  output  1  high in RUN state.
REQ-010 led_step  output  1  high in STOP state.
REQ-011 led_run  output  CNT_W  current step count.
REQ-012 state_o  output  2  encoded state: IDLE=0, RUN=1, STOP=2, STEP=3.

Function
REQ-013 Each button SHALL pass through a two-flop synchroniser, then a per-button debouncer.
REQ-014 The debouncer SHALL update its level only after the synchronised input differs from it for DB_CYCLES consecutive cycles.
  - Any equal sample clears the count.
  - A stable raw transition reaches the debounced level exactly DB_CYCLES+2 cycles after first sampling.
REQ-015 A rising edge of a debounced level SHALL produce exactly one single-cycle press event; holding a button SHALL NOT produce repeats, and releases SHALL produce no event.
REQ-016 The state machine SHALL be Moore: mic1_run, led_start_stop, led_step and state_o are decoded from the state register only.
REQ-017 Press priority when several events coincide: RESET_SYNC > STOP > STEP > RUN; only the highest-priority event is acted on.
REQ-018 IDLE: RUN -> RUN; STEP -> STEP; STOP ignored; mic1_run=0.
REQ-019 RUN: STOP -> STOP; STEP and RUN ignored; mic1_run=1.
REQ-020 STOP: RUN -> RUN; STEP -> STEP; STOP ignored; mic1_run=0.
REQ-021 STEP: mic1_run=1 for exactly STEP_LEN cycles, then -> STOP.
  - STOP press aborts the step immediately -> STOP.
  - RUN and STEP presses are ignored while in STEP.
REQ-022 The step counter SHALL increment by 1 on every entry into STEP and wrap modulo 2^CNT_W; led_run SHALL equal the counter.
REQ-023 RESET_SYNC press in any state: state -> IDLE, step counter and step-length counter cleared, and mic1_reset high for exactly the following cycle.
REQ-024 The step-length counter SHALL load on STEP entry and SHALL NOT carry over between steps.

Reset
REQ-025 Assertion of resetn SHALL immediately force the following, independent of clk:
  - state IDLE; all synchroniser, debouncer and counter flops to 0;
  - mic1_run=0, mic1_reset=0, led_start_stop=0, led_step=0, led_run=0, state_o=0.
REQ-026 A button held through reset deassertion SHALL yield one press event DB_CYCLES+2 cycles after deassertion.
REQ-027 Reset asserted during STEP SHALL abort the step with no further mic1_run cycles.

Verification (DB_CYCLES=4, STEP_LEN=3, CNT_W=4)
REQ-028 Hold button[0] 10 cycles from IDLE -> state_o=1, mic1_run=1, led_start_stop=1 from cycle 7; no repeat event.
REQ-029 button[2] glitch of 3 cycles in STOP -> no state change, led_run unchanged.
REQ-030 Sixteen STEP presses from STOP -> each gives exactly 3 mic1_run cycles then state_o=2; led_run runs 1..15 then wraps to 0.
REQ-031 button[0], button[3] and button[4] rise in the same cycle while in RUN -> IDLE, a single mic1_reset pulse, led_run=0.
REQ-032 STOP press in the second cycle of a step -> mic1_run low the following cycle, state_o=2.
REQ-033 resetn low mid-debounce and mid-step -> all outputs 0 asynchronously; held button[2] produces one step 6 cycles after release of reset.
